// File: rtl/mc14500b_prog_loader.sv
// Framed byte-stream loader for the MC14500B program RAM.
// Frame: SYNC, ADDR, LEN, LEN data bytes, CHK (XOR of ADDR, LEN and data); holds the CPU in reset while loading.
module mc14500b_prog_loader #(
  parameter int unsigned ADDR_W        = 8,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT       = 1000000,
  parameter logic        HOLD_AT_RESET = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [7:0]        WDATA,
  output logic              HOLD,
  output logic              BUSY,
  output logic              LOAD_OK,
  output logic              LOAD_ERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LEN    = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          chk_q, chk_d;
  logic [31:0]         timer_q, timer_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                accept_s, timing_s, expire_s;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    timer_d  = timer_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    ok_d     = 1'b0;
    err_d    = err_q;

    accept_s = IN_VALID && ready_q;
    timing_s = (state_q == S_ADDR) || (state_q == S_LEN) ||
               (state_q == S_DATA) || (state_q == S_CHK);
    expire_s = (TIMEOUT != 0) && timing_s && (timer_q == TIMEOUT_LAST);

    if (accept_s) begin
      timer_d = '0;
    end else if (timing_s) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s && (IN_DATA == SYNC_BYTE)) begin
          state_d = S_ADDR;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          chk_d   = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (accept_s) begin
          addr_d  = ADDR_W'(IN_DATA);
          chk_d   = chk_q ^ IN_DATA;
          state_d = S_LEN;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_LEN: begin
        if (accept_s) begin
          cnt_d   = IN_DATA;
          chk_d   = chk_q ^ IN_DATA;
          state_d = (IN_DATA == 8'h00) ? S_CHK : S_DATA;
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = IN_DATA;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 8'd1;
          chk_d   = chk_q ^ IN_DATA;
          state_d = (cnt_q == 8'd1) ? S_CHK : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (accept_s && (IN_DATA == chk_q)) begin
          state_d = S_COMMIT;
          ok_d    = 1'b1;
          hold_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (accept_s) begin
          // Bad checksum: keep HOLD so a corrupt image never runs
          state_d = S_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_CHK;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // An accepted byte always wins over an expiring timer
    if (expire_s && !accept_s) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      timer_d = '0;
    end else begin
      timer_d = timer_d;
    end

    ready_d = (state_d != S_COMMIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= 8'h00;
      chk_q   <= 8'h00;
      timer_q <= 32'd0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'h00;
      hold_q  <= HOLD_AT_RESET;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      timer_q <= timer_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign IN_READY = ready_q;
  assign WE       = we_q;
  assign WADDR    = waddr_q;
  assign WDATA    = wdata_q;
  assign HOLD     = hold_q;
  assign BUSY     = busy_q;
  assign LOAD_OK  = ok_q;
  assign LOAD_ERR = err_q;

endmodule

// File: doc/mc14500b_prog_loader.md
Name: mc14500b_prog_loader

Overview:
Byte-stream program loader for the MC14500B demo program memory: the writer side of the instruction memory that the ICU reads.
- Accepts framed bytes from a byte source (UART RX or debug bridge) and writes instruction words into the program RAM.
- Holds the processor in reset while loading and releases it on a verified frame.
- Sits between the byte source and the RAM write port / processor reset in the FPGA top level.

Parameters:
ADDR_W, 8, program memory address width; addresses wrap mod 2^ADDR_W.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 1000000, inter-byte timeout in CLK cycles; 0 disables the timeout.
HOLD_AT_RESET, 1'b0, value of HOLD after reset.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  asynchronous, active-low reset.
IN_DATA  input  8  incoming byte.
IN_VALID  input  1  IN_DATA valid.
IN_READY  output  1  loader can accept a byte.
WE  output  1  program RAM write strobe, one cycle per word.
WADDR  output  ADDR_W  program RAM write address.
WDATA  output  8  instruction word: opcode[7:4], I/O address[3:0].
HOLD  output  1  processor held in reset while high.
BUSY  output  1  frame in progress.
LOAD_OK  output  1  one-cycle pulse on a verified frame.
LOAD_ERR  output  1  sticky error flag.

Behaviour:
- Reset values (asynchronous, RST low): state IDLE; IN_READY=1; WE=0; WADDR=0; WDATA=0; HOLD=HOLD_AT_RESET; BUSY=0; LOAD_OK=0; LOAD_ERR=0; checksum, counters and timer all 0.
- A byte is accepted on a rising edge with IN_VALID & IN_READY.
- IN_READY is 1 in every state except COMMIT.
- Frame format: SYNC, ADDR, LEN, LEN data bytes, CHK.
  - CHK = XOR of ADDR, LEN and all data bytes.
  - LEN=0 means no data bytes.
- State machine:
  - IDLE: non-SYNC bytes are dropped. On SYNC: go to ADDR; HOLD<=1, BUSY<=1, LOAD_ERR<=0, chk<=0.
  - ADDR: latch the start address, chk^=byte, go to LEN.
  - LEN: latch the remaining count, chk^=byte. Go to DATA if LEN!=0, otherwise go to CHK.
  - DATA: each byte is written immediately.
    - WE=1 on the following cycle, with WADDR = current address and WDATA = byte.
    - Then address+1 (wraps), count-1, chk^=byte.
    - Go to CHK when count reaches 0.
  - CHK: if the byte equals chk, go to COMMIT. Otherwise go to IDLE with LOAD_ERR<=1, BUSY<=0, HOLD kept at 1.
  - COMMIT (1 cycle): IN_READY=0, LOAD_OK=1, HOLD<=0, BUSY<=0, then IDLE.
- Write latency: WE is asserted exactly 1 cycle after the accepting edge. Back-to-back bytes give back-to-back WE pulses.
- Failed frames: data already written is not rolled back. HOLD stays high so a corrupt image never runs. Only a later good frame clears HOLD (or reset, if HOLD_AT_RESET=0).
- SYNC_BYTE value inside ADDR, LEN, DATA or CHK is treated as data; there is no resync.
- Timeout:
  - Timer runs only while BUSY and clears on each accepted byte.
  - When the timer reaches TIMEOUT: go to IDLE, LOAD_ERR<=1, BUSY<=0, HOLD stays 1, no write.
- Simultaneous events: a byte accepted on the same edge the timeout expires is taken and the timer restarts (no error).
- Reset mid-frame: everything returns to reset values immediately. A WE pulse in flight is cancelled.
- Writes wrap: start address 2^ADDR_W-1 followed by 0.

Test Plan:
- Frame A5 10 02 3C 4D 63 → WE at [0x10]=0x3C then [0x11]=0x4D, one cycle after each accept. LOAD_OK pulses once. HOLD 1→0. LOAD_ERR=0.
- Same frame with CHK=64 → both writes occur. LOAD_ERR=1, HOLD stays 1, no LOAD_OK. Then a good frame A5 20 00 20 → LOAD_OK, LOAD_ERR=0, HOLD=0, no WE.
- Wrap frame A5 FF 02 11 22 CE → [0xFF]=0x11, [0x00]=0x22, LOAD_OK.
- Idle garbage 00 5A FF, then A5 10 01 A5 B4 (0x10^0x01^0xA5) → single write [0x10]=0xA5. Embedded A5 is treated as data.
- TIMEOUT=16: send A5 10 02 3C, then idle 16 cycles → LOAD_ERR=1, BUSY=0, HOLD=1, only [0x10] written. Stall of 15 cycles between bytes → no error.
- RST low for 1 cycle after A5 10 → all outputs at reset values, HOLD=HOLD_AT_RESET, no WE. Next full good frame loads normally.
